song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
- Upstream driver for the tone generator: steps through a song stored in an external synchronous ROM.
- Produces the one-hot note vector and octave flags the tone generator consumes: notes[6:0] (bit 6 = do ... bit 0 = si), ishigher, islower.
- Each entry is held for a programmable number of beats, followed by a short silent articulation gap.
- Controlled by start / pause / stop from the user-input layer.

Parameters:
- BEAT_TICKS, 25_000_000, clk cycles per beat (250 ms at 100 MHz); BEAT_TICKS*8 must be < 2^32.
- GAP_TICKS, 2_000_000, silent clk cycles after every entry; 0 means no gap.
- ADDR_W, 6, ROM address width (song length up to 2^ADDR_W entries).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin playback from address 0 (sampled; ignored while busy)
- pause  in  1  level; freeze and silence playback while high
- stop  in  1  abort playback, return to idle
- rom_addr  out  ADDR_W  ROM read address (ROM registers data one cycle later)
- rom_data  in  8  entry: [7:5] note code (0 = rest, 1..7 = do..si), [4:3] octave (00 mid, 01 high, 10 low, 11 end marker), [2:0] beats-1
- notes  out  7  one-hot note to tone generator, 0 = silence
- ishigher  out  1  high-octave flag
- islower  out  1  low-octave flag
- busy  out  1  high from start acceptance until return to IDLE
- done  out  1  one-cycle pulse at song end

Behaviour:
- Reset (async, rst_n=0): state IDLE, rom_addr=0, notes=0, ishigher=0, islower=0, busy=0, done=0, counter=0. All outputs are registered.
- States: IDLE, FETCH, LOAD, PLAY, GAP.
- IDLE: on start (and no stop): rom_addr<=0, busy<=1, go to FETCH.
- FETCH: one cycle; the ROM registers rom_data for rom_addr. Go to LOAD.
- LOAD, end marker (octave 11, any note code): done<=1 for one cycle, busy<=0, outputs 0, go to IDLE.
- LOAD, otherwise:
  - Latch the entry. notes <= one-hot(code), or 0 for a rest.
  - ishigher <= (oct==01), islower <= (oct==10). The two flags are never both 1.
  - counter <= (beats-1+1)*BEAT_TICKS - 1. Go to PLAY.
- Latency: start sampled at edge E0; notes valid after E2 (2 cycles).
- PLAY: hold outputs, decrement counter.
  - At 0: notes/ishigher/islower <= 0.
  - If GAP_TICKS>0: counter <= GAP_TICKS-1, go to GAP. Otherwise advance.
- GAP: outputs 0, decrement counter; at 0 advance.
- Advance: if rom_addr == 2^ADDR_W-1, treat as end (done pulse, IDLE). Otherwise rom_addr+1, go to FETCH.
- Entry period: (beats)*BEAT_TICKS sounding cycles + GAP_TICKS silent cycles + 2 fetch cycles.
- pause high in PLAY/GAP:
  - Counter frozen; notes/ishigher/islower forced 0.
  - On release, the latched note is restored the next cycle and the remaining count continues.
  - pause is ignored in IDLE/FETCH/LOAD; FETCH/LOAD complete and the block stalls on entry to PLAY.
- stop, any state: next edge goes to IDLE, outputs 0, busy 0, rom_addr 0, no done pulse.
- Priority: stop > pause > start. start while busy is ignored.
- Counter: 32 bits, unsigned; no overflow by the parameter constraint.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: end marker or address wrap pulses done for one cycle, keeps busy=1, sets rom_addr<=0 and goes to FETCH (continuous loop until stop).
- Undefined: end returns to IDLE as described above.

Test Plan:
- Common bench parameters: BEAT_TICKS=10, GAP_TICKS=2, ADDR_W=4.
- Reset mid-PLAY: assert rst_n=0 -> all outputs 0 immediately; busy=0 and rom_addr=0 after release.
- ROM[0]=0x20 (do, mid, 1 beat), ROM[1]=0x18 (end); pulse start -> notes=7'b1000000 exactly 10 cycles starting 2 cycles after start; 2 cycles of 0; done pulses once at 16 cycles after start; busy falls with done.
- ROM[0]=0xC9 (la, high, 2 beats) -> notes=7'b0000010, ishigher=1, islower=0 for 20 cycles. ROM[1]=0xF0 (si, low, 1 beat) -> notes=7'b0000001, islower=1 for 10 cycles.
- Pause high for 5 cycles at the 4th cycle of a 1-beat note -> outputs 0 during pause; total sounding cycles still 10; done delayed by 5 cycles.
- stop pulse mid-PLAY -> next cycle notes=0 and busy=0, no done pulse. start asserted while busy -> no restart (rom_addr unchanged).
- ROM filled with 0x02 (rest, 3 beats), no end marker -> notes=0 throughout, busy=1; 16 entries of 34 cycles each, then done (loop variant: restarts at addr 0, busy stays 1).

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: walks a song ROM and drives one-hot notes to the tone generator.
// Optional SONG_LOOP_EN: at song end, replay from address 0 instead of idling.
module song_sequencer #(
  parameter int BEAT_TICKS = 25_000_000,
  parameter int GAP_TICKS  = 2_000_000,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [6:0]        notes,
  output logic              ishigher,
  output logic              islower,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, PLAY, GAP
  } state_t;

  localparam logic [31:0] BEAT = 32'(BEAT_TICKS);
  localparam logic [31:0] GAP_LD =
    (GAP_TICKS > 0) ? 32'(GAP_TICKS - 1) : 32'd0;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [6:0]        notes_n, lat, lat_n;
  logic              hi_n, lo_n;
  logic              lat_hi, lat_hi_n;
  logic              lat_lo, lat_lo_n;
  logic              busy_n, done_n;
  logic [31:0]       cnt, cnt_n;
  logic              adv, fin;
  logic [2:0]        code;
  logic [1:0]        oct;
  logic [31:0]       beats;

  assign code  = rom_data[7:5];
  assign oct   = rom_data[4:3];
  assign beats = 32'(rom_data[2:0]) + 32'd1;

  function automatic logic [6:0] onehot(
    input logic [2:0] c
  );
    logic [6:0] r;
    case (c)
      3'd1:    r = 7'b1000000;
      3'd2:    r = 7'b0100000;
      3'd3:    r = 7'b0010000;
      3'd4:    r = 7'b0001000;
      3'd5:    r = 7'b0000100;
      3'd6:    r = 7'b0000010;
      3'd7:    r = 7'b0000001;
      default: r = 7'b0000000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rom_addr <= '0;
      notes    <= '0;
      ishigher <= 1'b0;
      islower  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      lat      <= '0;
      lat_hi   <= 1'b0;
      lat_lo   <= 1'b0;
    end else begin
      state    <= state_n;
      rom_addr <= addr_n;
      notes    <= notes_n;
      ishigher <= hi_n;
      islower  <= lo_n;
      busy     <= busy_n;
      done     <= done_n;
      cnt      <= cnt_n;
      lat      <= lat_n;
      lat_hi   <= lat_hi_n;
      lat_lo   <= lat_lo_n;
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = rom_addr;
    notes_n  = notes;
    hi_n     = ishigher;
    lo_n     = islower;
    busy_n   = busy;
    done_n   = 1'b0;
    cnt_n    = cnt;
    lat_n    = lat;
    lat_hi_n = lat_hi;
    lat_lo_n = lat_lo;
    adv      = 1'b0;
    fin      = 1'b0;
    if (stop) begin
      state_n = IDLE;
      addr_n  = '0;
      notes_n = '0;
      hi_n    = 1'b0;
      lo_n    = 1'b0;
      busy_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr_n  = '0;
            busy_n  = 1'b1;
            state_n = FETCH;
          end
        end
        FETCH: state_n = LOAD;
        LOAD: begin
          if (oct == 2'b11) begin
            fin = 1'b1;
          end else begin
            lat_n    = onehot(code);
            lat_hi_n = (oct == 2'b01);
            lat_lo_n = (oct == 2'b10);
            notes_n  = lat_n;
            hi_n     = lat_hi_n;
            lo_n     = lat_lo_n;
            cnt_n    = beats * BEAT - 32'd1;
            state_n  = PLAY;
          end
        end
        PLAY: begin
          // paused: silent and frozen; latched note survives
          notes_n = '0;
          hi_n    = 1'b0;
          lo_n    = 1'b0;
          if (!pause) begin
            if (cnt == '0) begin
              if (GAP_TICKS > 0) begin
                cnt_n   = GAP_LD;
                state_n = GAP;
              end else begin
                adv = 1'b1;
              end
            end else begin
              notes_n = lat;
              hi_n    = lat_hi;
              lo_n    = lat_lo;
              cnt_n   = cnt - 32'd1;
            end
          end
        end
        GAP: begin
          notes_n = '0;
          hi_n    = 1'b0;
          lo_n    = 1'b0;
          if (!pause) begin
            if (cnt == '0) adv = 1'b1;
            else cnt_n = cnt - 32'd1;
          end
        end
        default: state_n = IDLE;
      endcase
      if (adv) begin
        if (rom_addr == '1) begin
          fin = 1'b1;
        end else begin
          addr_n  = rom_addr + ADDR_W'(1);
          state_n = FETCH;
        end
      end
      if (fin) begin
        done_n  = 1'b1;
        notes_n = '0;
        hi_n    = 1'b0;
        lo_n    = 1'b0;
`ifdef SONG_LOOP_EN
        addr_n  = '0;
        state_n = FETCH;
`else
        busy_n  = 1'b0;
        state_n = IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: table vectors, directed corners and random songs
// checked every cycle against a queue-of-cycles reference model.
module tb_song_sequencer;

  localparam int BT = 10;
  localparam int GT = 2;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [6:0]    notes;
  logic          ishigher, islower, busy, done;
  logic [7:0]    rom [N];

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  song_sequencer #(
    .BEAT_TICKS(BT),
    .GAP_TICKS (GT),
    .ADDR_W    (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pause   (pause),
    .stop    (stop),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .notes   (notes),
    .ishigher(ishigher),
    .islower (islower),
    .busy    (busy),
    .done    (done)
  );

  // one record per output cycle; pz = produced by a pausable edge
  typedef struct packed {
    logic [6:0]    n;
    logic          hi;
    logic          lo;
    logic [AW-1:0] a;
    logic          busy;
    logic          done;
    logic          pz;
  } item_t;

  item_t q[$];
  item_t exp_o = '0;

  typedef struct {
    logic [7:0] rom;
    logic [6:0] n;
    logic       hi;
    logic       lo;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [6:0] tone(input logic [2:0] c);
    logic [7:0] one;
    one = 8'd1;
    if (c == 3'd0) return 7'd0;
    return 7'(one << (7 - int'(c)));
  endfunction

  task automatic build();
    item_t it;
    logic [7:0] b;
    int len;
    q.delete();
    for (int i = 0; i < N; i++) begin
      b = rom[i];
      it = '0;
      it.a = AW'(i);
      it.busy = 1'b1;
      it.pz = (i != 0);
      q.push_back(it);
      it.pz = 1'b0;
      q.push_back(it);
      if (b[4:3] == 2'b11) begin
        it.busy = 1'b0;
        it.done = 1'b1;
        q.push_back(it);
        return;
      end
      len = (int'(b[2:0]) + 1) * BT;
      for (int k = 0; k < len; k++) begin
        it.n = tone(b[7:5]);
        it.hi = (b[4:3] == 2'b01);
        it.lo = (b[4:3] == 2'b10);
        it.pz = (k != 0);
        q.push_back(it);
      end
      it.n = '0;
      it.hi = 1'b0;
      it.lo = 1'b0;
      it.pz = 1'b1;
      for (int k = 0; k < GT; k++) q.push_back(it);
    end
    it = '0;
    it.a = AW'(N - 1);
    it.done = 1'b1;
    it.pz = 1'b1;
    q.push_back(it);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      q.delete();
      exp_o = '0;
    end else if (stop) begin
      q.delete();
      exp_o = '0;
    end else if (q.size() == 0) begin
      if (start) begin
        build();
        exp_o = q.pop_front();
      end else begin
        exp_o.n = '0;
        exp_o.hi = 1'b0;
        exp_o.lo = 1'b0;
        exp_o.busy = 1'b0;
        exp_o.done = 1'b0;
      end
    end else if (pause && q[0].pz) begin
      exp_o.n = '0;
      exp_o.hi = 1'b0;
      exp_o.lo = 1'b0;
      exp_o.busy = 1'b1;
      exp_o.done = 1'b0;
    end else begin
      exp_o = q.pop_front();
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    ntests++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step(input logic st, input logic pa, input logic sp);
    @(negedge clk);
    start = st;
    pause = pa;
    stop  = sp;
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle",
        32'({notes, ishigher, islower, rom_addr, busy, done}),
        32'({exp_o.n, exp_o.hi, exp_o.lo, exp_o.a,
             exp_o.busy, exp_o.done}));
  endtask

  task automatic set_song(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c);
    rom[0] = a;
    rom[1] = b;
    for (int i = 2; i < N; i++) rom[i] = c;
  endtask

  initial begin
    int cnt, cnt2, first, dat, dcnt, bad;
    logic pa, st, sp;
    logic [7:0] b;

    tbl[0] = '{8'h20, 7'b1000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'hC9, 7'b0000010, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'hF0, 7'b0000001, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h40, 7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h60, 7'b0010000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h80, 7'b0001000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{8'hA8, 7'b0000100, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8'h58, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b1};

    set_song(8'h18, 8'h18, 8'h18);
    repeat (3) @(negedge clk);
    chk("reset_state",
        32'({notes, ishigher, islower, rom_addr, busy, done}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      set_song(tbl[i].rom, 8'h18, 8'h18);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("tbl_out",
          32'({notes, ishigher, islower, busy, done}),
          32'({tbl[i].n, tbl[i].hi, tbl[i].lo, tbl[i].busy, tbl[i].done}));
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end

    // one-beat do then end marker
    set_song(8'h20, 8'h18, 8'h18);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0; first = -1; dat = -1; dcnt = 0;
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (notes == 7'b1000000) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (done) begin
        dcnt++;
        dat = i;
        chk("t1_busy_at_done", 32'(busy), 32'd0);
      end
    end
    chk("t1_sound", cnt, 10);
    chk("t1_first", first, 2);
    chk("t1_done_at", dat, 16);
    chk("t1_done_cnt", dcnt, 1);

    // octave flags
    set_song(8'hC9, 8'hF0, 8'h18);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0; cnt2 = 0; dat = -1;
    for (int i = 1; i <= 45; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (notes == 7'b0000010 && ishigher && !islower) cnt++;
      if (notes == 7'b0000001 && islower && !ishigher) cnt2++;
      if (done) dat = i;
    end
    chk("t2_high", cnt, 20);
    chk("t2_low", cnt2, 10);
    chk("t2_done_at", dat, 40);

    // pause 5 cycles from the 4th sounding cycle
    set_song(8'h20, 8'h18, 8'h18);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0; cnt2 = 0; dat = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, (i >= 5 && i <= 9), 1'b0);
      if (notes != '0) cnt++;
      if (i >= 5 && i <= 9 && notes != '0) cnt2++;
      if (done) dat = i;
    end
    chk("t3_sound", cnt, 10);
    chk("t3_quiet", cnt2, 0);
    chk("t3_done_at", dat, 21);

    // start while busy, then stop mid-PLAY
    set_song(8'h20, 8'h27, 8'h18);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t4_no_restart", 32'({rom_addr, notes}),
        32'({4'd1, 7'b1000000}));
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("t4_stop", 32'({notes, busy, rom_addr}), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done) dcnt++;
    end
    chk("t4_no_done", dcnt, 0);

    // reset while playing
    set_song(8'h27, 8'h18, 8'h18);
    step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_rst",
        32'({notes, ishigher, islower, busy, done}), 32'd0);
    q.delete();
    exp_o = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("t5_after_rst", 32'({busy, rom_addr}), 32'd0);

    // all rests, no end marker: wraps after 16 entries
    set_song(8'h02, 8'h02, 8'h02);
    step(1'b1, 1'b0, 1'b0);
    cnt = 0; bad = 0; dat = -1;
    for (int i = 1; i <= 560; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (notes != '0) cnt++;
      if (i < 544 && !busy) bad++;
      if (done && dat < 0) dat = i;
    end
    chk("t6_silent", cnt, 0);
    chk("t6_busy", bad, 0);
    chk("t6_done_at", dat, 544);

    // random songs with random pause/start/stop
    for (int s = 0; s < 8; s++) begin
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) begin
        b = 8'($urandom);
        if (s % 3 == 0 && b[4:3] == 2'b11) b[4:3] = 2'b00;
        rom[i] = b;
      end
      pa = 1'b0;
      for (int c = 0; c < 4000 && (c == 0 || q.size() > 0); c++) begin
        if ($urandom_range(19) == 0) pa = ~pa;
        st = ($urandom_range(29) == 0);
        sp = ($urandom_range(999) == 0);
        step((c == 0) ? 1'b1 : st, pa, sp);
      end
      repeat (3) step(1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
